ram_blk_sp_ctrl: RTL
====================

# ram_blk_sp_ctrl

Initiator-side controller for a single-port synchronous block RAM with one-cycle read latency and read-first behaviour. It accepts read and write requests on a valid/ready port, drives the RAM address, write-enable and write-data pins, and returns read data in order on a 2-entry buffered valid/ready response port. It also zero-fills the whole RAM after reset and on command. Cache tag and data arrays use it as their access front end.

## Interface
- DATAWIDTH, 8, RAM word width
- ADDRWIDTH, 9, RAM address width; depth = 2^ADDRWIDTH
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- clear  in  1  one-cycle pulse; zero-fills the RAM (accepted only in RUN)
- busy  out  1  high while the FSM is in CLEAR
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDRWIDTH  request address
- req_wr_data  in  DATAWIDTH  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rd_data  out  DATAWIDTH  read data, head of response buffer
- ram_addr  out  ADDRWIDTH  to RAM addr
- ram_we  out  1  to RAM we
- ram_wr_data  out  DATAWIDTH  to RAM wr_data
- ram_rd_data  in  DATAWIDTH  from RAM rd_data; valid the cycle after the address is presented

## Operation
- FSM has two states, CLEAR and RUN. Reset enters CLEAR with clear counter = 0.
- CLEAR:
  - ram_addr = counter, ram_wr_data = 0, ram_we = 1. ram_we is forced to 0 while reset is high.
  - Counter increments each cycle. On the cycle counter = 2^ADDRWIDTH-1, the counter wraps to 0 and the next state is RUN.
  - busy = 1 and req_ready = 0 throughout.
  - clear is ignored in CLEAR.
- RUN:
  - ram_addr = req_addr, ram_wr_data = req_wr_data, ram_we = req_valid && req_ready && req_we. All three are combinational.
  - A clear pulse moves the FSM to CLEAR on the next cycle. A request accepted in the same cycle as clear still executes.
- Read tracking:
  - inflight (1 bit) is set on the cycle after an accepted read.
  - When inflight is high, ram_rd_data is pushed into the response FIFO (occ 0..2) at the end of that cycle.
- req_ready in RUN = (occ + inflight < 2) || (rsp_valid && rsp_ready). It does not depend on req_we.
- Writes produce no response. Responses return in request order.
- Outstanding reads complete normally across a clear and are never dropped, whether in flight or buffered.
- A read following a write to the same address (any later cycle) returns the new data.

## Timing
- Reset values: busy = 1, req_ready = 0, rsp_valid = 0, ram_we = 0, occ = 0, inflight = 0.
- Read latency: accept in cycle N gives ram_rd_data in N+1, pushed to the FIFO at the end of N+1, rsp_valid in N+2.
- Throughput: one request per cycle sustained while rsp_ready = 1.
- rsp_ready = 0: at most 2 reads are outstanding (buffered + inflight), then req_ready = 0.
- Simultaneous push and pop: occ is unchanged and the order is preserved.
- rsp_rd_data is held stable while rsp_valid && !rsp_ready.
- Clear duration:
  - Exactly 2^ADDRWIDTH cycles with ram_we = 1.
  - busy falls and req_ready may rise on the first cycle after the last clear write.
- Reset mid-CLEAR or mid-RUN: FIFO and inflight are emptied and clearing restarts at address 0.

## Test plan
- Reset release, ADDRWIDTH=4:
  - Response: busy = 1 for 16 cycles; ram_we = 1 with ram_addr 0..15 and ram_wr_data 0.
  - Response: cycle 17, busy = 0 and req_ready = 1.
- Write 0xA5 to addr 3, then read addr 3 on the next cycle -> rsp_valid two cycles after the read accept, rsp_rd_data = 0xA5.
- 16 back-to-back reads with rsp_ready = 1 -> req_ready stays 1; 16 responses on consecutive cycles, in address order.
- rsp_ready = 0, issue 4 reads:
  - Response: 2 reads accepted, then req_ready = 0; rsp_rd_data holds the first result.
  - Response: raising rsp_ready drains all 4 in order with no loss or duplication.
- Write 0x3C to addr 5, read addr 5, pulse clear in the read-accept cycle -> response = 0x3C; busy for 2^ADDRWIDTH cycles; a later read of addr 5 returns 0.
- Assert reset in the middle of CLEAR with a buffered response pending -> rsp_valid = 0 immediately; clearing restarts at ram_addr 0.

Source files
------------

// File: rtl/ram_blk_sp_ctrl.sv
// ram_blk_sp_ctrl: single-port block RAM front end with zero-fill, in-order read return and 2-entry response buffer
module ram_blk_sp_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wr_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rd_data,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic                 ram_we,
  output logic [DATAWIDTH-1:0] ram_wr_data,
  input  logic [DATAWIDTH-1:0] ram_rd_data
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [ADDRWIDTH-1:0] cnt;
  logic inflight, wptr, rptr, run, accept, pop;
  logic [1:0] occ;
  logic [DATAWIDTH-1:0] mem [2];
  always_comb begin
    run = state == RUN;
    busy = !run;
    rsp_valid = occ != 2'd0;
    pop = rsp_valid && rsp_ready;
    req_ready = run && ((occ + {1'b0, inflight} < 2'd2) || pop);
    accept = req_valid && req_ready;
    ram_addr = run ? req_addr : cnt;
    ram_wr_data = run ? req_wr_data : '0;
    ram_we = run ? accept && req_we : !reset;
    rsp_rd_data = mem[rptr];
  end
  // read tracking runs independently of the FSM so reads survive a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
      inflight <= 1'b0;
      occ <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      inflight <= accept && !req_we;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      wptr <= wptr ^ inflight;
      rptr <= rptr ^ pop;
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= RUN;
      end else if (clear) state <= CLEAR;
    end
  end
  always_ff @(posedge clk)
    if (inflight) mem[wptr] <= ram_rd_data;
endmodule
